// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and width helpers for the UART command engine.
package uart_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TX_SEND = 3'd1;
  localparam logic [2:0] ST_TX_WAIT = 3'd2;
  localparam logic [2:0] ST_RX_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  function automatic int cmd_w(input int data_width, input int cmd_bytes);
    return data_width * cmd_bytes;
  endfunction

  function automatic int rsp_w(input int data_width, input int rd_bytes);
    return data_width * rd_bytes;
  endfunction

  // One counter serves both the TX and RX phases, so it must cover the longer one.
  function automatic int cnt_w(input int cmd_bytes, input int rd_bytes);
    return $clog2(((cmd_bytes > rd_bytes) ? cmd_bytes : rd_bytes) + 1);
  endfunction

  function automatic int to_w(input int timeout_cycles);
    return $clog2(timeout_cycles);
  endfunction

  function automatic int default_timeout(input int sys_clk_freq, input int bps);
    return 20 * sys_clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_cmd_engine_if.sv
// rtl/uart_cmd_engine_if.sv - host command, response and UART byte-engine signals of the command engine.
interface uart_cmd_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_BYTES  = 2,
  parameter int RD_BYTES   = 1
);
  import uart_pkg::*;

  logic [cmd_w(DATA_WIDTH, CMD_BYTES)-1:0] cmd;
  logic                                    uart_valid;
  logic                                    uart_ready;
  logic [rsp_w(DATA_WIDTH, RD_BYTES)-1:0]  read_data;
  logic                                    read_valid;
  logic                                    rd_timeout;
  logic                                    cmd_done;
  logic [DATA_WIDTH-1:0]                   tx_data;
  logic                                    tx_en;
  logic                                    tx_done;
  logic [DATA_WIDTH-1:0]                   rx_data;
  logic                                    rx_done;

  modport master (
    output cmd, uart_valid, tx_done, rx_data, rx_done,
    input  uart_ready, read_data, read_valid, rd_timeout, cmd_done, tx_data, tx_en
  );

  modport slave (
    input  cmd, uart_valid, tx_done, rx_data, rx_done,
    output uart_ready, read_data, read_valid, rd_timeout, cmd_done, tx_data, tx_en
  );

endinterface

// File: rtl/uart_timeout_cnt.sv
// rtl/uart_timeout_cnt.sv - saturating idle counter; expire flags the last allowed idle cycle.
module uart_timeout_cnt
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int             W    = to_w(TIMEOUT_CYCLES);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_engine.sv
// rtl/uart_cmd_engine.sv - serialises a command packet MSByte-first to UART TX and collects read responses from RX.
module uart_cmd_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CMD_BYTES      = 2,
  parameter int RD_BYTES       = 1,
  parameter int BPS            = 115_200,
  parameter int SYS_CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_CYCLES = default_timeout(SYS_CLK_FREQ, BPS)
) (
  input logic              clk,
  input logic              rst,
  uart_cmd_engine_if.slave bus
);

  localparam int CW = cmd_w(DATA_WIDTH, CMD_BYTES);
  localparam int RW = rsp_w(DATA_WIDTH, RD_BYTES);
  localparam int NW = cnt_w(CMD_BYTES, RD_BYTES);

  logic [2:0]    state;
  logic [CW-1:0] shreg;
  logic [RW-1:0] rsp;
  logic [RW-1:0] rsp_next;
  logic [RW-1:0] read_data_q;
  logic [NW-1:0] byte_cnt;
  logic          is_read;
  logic          rd_ok;
  logic          tx_last;
  logic          rx_last;
  logic          to_expire;

  assign tx_last  = (byte_cnt == NW'(CMD_BYTES - 1));
  assign rx_last  = (byte_cnt == NW'(RD_BYTES - 1));
  assign rsp_next = (rsp << DATA_WIDTH) | RW'(bus.rx_data);

  // Held in reset outside RX_WAIT, so entering RX_WAIT always starts from zero.
  uart_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state != ST_RX_WAIT) || bus.rx_done),
    .en    (state == ST_RX_WAIT),
    .expire(to_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      rsp         <= '0;
      read_data_q <= '0;
      byte_cnt    <= '0;
      is_read     <= 1'b0;
      rd_ok       <= 1'b0;
    end else begin
      rd_ok <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.uart_valid) begin
            shreg    <= bus.cmd;
            is_read  <= ~bus.cmd[CW-1];
            byte_cnt <= '0;
            state    <= ST_TX_SEND;
          end
        end
        ST_TX_SEND: state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (bus.tx_done) begin
            shreg <= shreg << DATA_WIDTH;
            if (tx_last) begin
              byte_cnt <= '0;
              state    <= is_read ? ST_RX_WAIT : ST_DONE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= ST_TX_SEND;
            end
          end
        end
        ST_RX_WAIT: begin
          // A byte arriving in the expiry cycle takes priority over the timeout.
          if (bus.rx_done) begin
            rsp <= rsp_next;
            if (rx_last) begin
              read_data_q <= rsp_next;
              rd_ok       <= 1'b1;
              state       <= ST_DONE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (to_expire) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.uart_ready = (state == ST_IDLE) & ~rst;
  assign bus.tx_en      = (state == ST_TX_SEND);
  assign bus.tx_data    = shreg[CW-1 -: DATA_WIDTH];
  assign bus.read_valid = rd_ok;
  assign bus.read_data  = read_data_q;
  assign bus.cmd_done   = (state == ST_DONE);
  assign bus.rd_timeout = (state == ST_RX_WAIT) & to_expire & ~bus.rx_done & ~rst;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// tb/tb_uart_cmd_engine.sv - scoreboard bench: stimulus queues expected events, a negedge monitor checks them.
module tb_uart_cmd_engine;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int CB = 2;
  localparam int RB = 2;
  localparam int TC = 16;

  localparam int EV_TX     = 0;
  localparam int EV_TO     = 1;
  localparam int EV_END_WR = 2;
  localparam int EV_END_RD = 3;

  typedef struct {
    int          kind;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_engine_if #(.DATA_WIDTH(DW), .CMD_BYTES(CB), .RD_BYTES(RB)) bus ();

  uart_cmd_engine #(
    .DATA_WIDTH    (DW),
    .CMD_BYTES     (CB),
    .RD_BYTES      (RB),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ev_t         exp_q[$];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_err  = 0;
  logic        busy   = 1'b0;
  logic        mon_on = 1'b0;
  logic [15:0] last_rd = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: DUT produced an event with no expectation queued (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_on) begin
      chk("uart_ready", bus.uart_ready, {31'd0, !busy && !rst});
      if (bus.tx_en === 1'b1) begin
        if (exp_q.size() == 0) unexpected("tx_en");
        else begin
          e = exp_q.pop_front();
          chk("tx_kind", e.kind, EV_TX);
          chk("tx_data", bus.tx_data, e.data);
          chk("tx_en_cycle", cyc, e.cyc);
        end
      end
      if (bus.rd_timeout === 1'b1) begin
        if (exp_q.size() == 0) unexpected("rd_timeout");
        else begin
          e = exp_q.pop_front();
          chk("timeout_kind", e.kind, EV_TO);
          chk("rd_timeout_cycle", cyc, e.cyc);
        end
      end
      if (bus.cmd_done === 1'b1) begin
        if (exp_q.size() == 0) unexpected("cmd_done");
        else begin
          e = exp_q.pop_front();
          chk("done_kind_is_end", {31'd0, e.kind == EV_END_WR || e.kind == EV_END_RD}, 1);
          chk("read_valid_at_done", bus.read_valid, {31'd0, e.kind == EV_END_RD});
          chk("read_data_at_done", bus.read_data, e.data);
          chk("cmd_done_cycle", cyc, e.cyc);
        end
      end else begin
        chk("read_valid_outside_done", bus.read_valid, 0);
      end
      if (rst || bus.cmd_done) busy = 1'b0;
      if (!rst && bus.uart_valid && bus.uart_ready) busy = 1'b1;
    end
  end

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [15:0] c, input bit keep, output int hs);
    bus.cmd        = c;
    bus.uart_valid = 1'b1;
    hs             = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.uart_ready === 1'b1) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL handshake: uart_ready never rose within 200 cycles (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    if (!keep) bus.uart_valid = 1'b0;
  endtask

  // The byte engine returns tx_done 10 cycles after tx_en; optionally drops a stray rx byte meanwhile.
  task automatic tx_byte(input logic [7:0] b, input int s, input bit stray, output int d);
    exp_q.push_back('{kind: EV_TX, data: {8'h00, b}, cyc: s});
    if (stray) begin
      wait_to(s + 3);
      bus.rx_data = 8'hFF;
      bus.rx_done = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_done = 1'b0;
    end
    wait_to(s + 10);
    bus.tx_done = 1'b1;
    d = cyc;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input int at, output int r);
    wait_to(at);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    r = cyc;
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic send_tx(input logic [15:0] c, input bit stray, output int d);
    int hs;
    int d1;
    issue(c, 1'b0, hs);
    tx_byte(c[15:8], hs + 1, stray, d1);
    tx_byte(c[7:0], d1 + 1, 1'b0, d);
  endtask

  task automatic push_end(input int kind, input logic [15:0] data, input int at);
    exp_q.push_back('{kind: kind, data: data, cyc: at});
  endtask

  initial begin : watchdog
    #500000;
    n_chk++;
    n_err++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : stimulus
    int hs, hs2, d, d2, r1, r2, e;
    bus.cmd        = '0;
    bus.uart_valid = 1'b0;
    bus.tx_done    = 1'b0;
    bus.rx_data    = '0;
    bus.rx_done    = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_en", bus.tx_en, 0);
    chk("reset_tx_data", bus.tx_data, 0);
    chk("reset_read_data", bus.read_data, 0);
    chk("reset_read_valid", bus.read_valid, 0);
    chk("reset_rd_timeout", bus.rd_timeout, 0);
    chk("reset_cmd_done", bus.cmd_done, 0);
    chk("reset_uart_ready", bus.uart_ready, 0);
    rst    = 1'b0;
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    // Write 8A5C, then a stray tx_done while idle.
    send_tx(16'h8A5C, 1'b0, d2);
    push_end(EV_END_WR, last_rd, d2 + 1);
    wait_to(d2 + 4);
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;
    wait_to(cyc + 3);

    // Read 0312 -> DEAD, with a stray rx byte during TX_WAIT.
    send_tx(16'h0312, 1'b1, d2);
    rx_byte(8'hDE, d2 + 3, r1);
    rx_byte(8'hAD, r1 + 2, r2);
    last_rd = 16'hDEAD;
    push_end(EV_END_RD, last_rd, r2 + 1);
    wait_to(r2 + 4);

    // Timeout after one of two response bytes.
    send_tx(16'h0001, 1'b0, d2);
    rx_byte(8'h77, d2 + 2, r1);
    exp_q.push_back('{kind: EV_TO, data: 16'h0000, cyc: r1 + 16});
    push_end(EV_END_WR, last_rd, r1 + 17);
    wait_to(r1 + 20);

    // Second byte lands exactly in the expiry cycle.
    send_tx(16'h7F00, 1'b0, d2);
    rx_byte(8'hC3, d2 + 2, r1);
    rx_byte(8'h3C, r1 + 16, r2);
    last_rd = 16'hC33C;
    push_end(EV_END_RD, last_rd, r2 + 1);
    wait_to(r2 + 20);

    // Back-pressure: uart_valid held across two writes, cmd changed after capture.
    issue(16'h8111, 1'b1, hs);
    bus.cmd = 16'hC0DE;
    tx_byte(8'h81, hs + 1, 1'b0, d);
    tx_byte(8'h11, d + 1, 1'b0, d2);
    e = d2 + 1;
    push_end(EV_END_WR, last_rd, e);
    issue(16'hC0DE, 1'b0, hs2);
    chk("backpressure_accept_cycle", hs2, e + 1);
    tx_byte(8'hC0, hs2 + 1, 1'b0, d);
    tx_byte(8'hDE, d + 1, 1'b0, d2);
    push_end(EV_END_WR, last_rd, d2 + 1);
    wait_to(d2 + 4);

    // Reset in the middle of a read, then a normal write.
    send_tx(16'h0100, 1'b0, d2);
    rx_byte(8'h11, d2 + 2, r1);
    wait_to(r1 + 2);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_during_rst", bus.uart_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_tx_en", bus.tx_en, 0);
    chk("post_rst_tx_data", bus.tx_data, 0);
    chk("post_rst_read_data", bus.read_data, 0);
    chk("post_rst_read_valid", bus.read_valid, 0);
    chk("post_rst_rd_timeout", bus.rd_timeout, 0);
    chk("post_rst_cmd_done", bus.cmd_done, 0);
    last_rd = 16'h0000;
    wait_to(cyc + 30);
    send_tx(16'h9234, 1'b0, d2);
    push_end(EV_END_WR, last_rd, d2 + 1);
    wait_to(d2 + 6);

    chk("events_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
- Parametrised successor to the single-byte UART command interface.
- Accepts one multi-byte command packet through a valid/ready handshake and serialises it MSByte-first onto the UART TX byte interface.
- For read commands, it collects a configurable number of response bytes from the UART RX byte interface, with a per-byte timeout.
- Sits between the host/command logic and the UART TX/RX byte engines.

Parameters:
- DATA_WIDTH, 8: UART byte width.
- CMD_BYTES, 2: command packet length in bytes. Bit [MSB] is R/W (0 = read, 1 = write); the remaining bits are address/data.
- RD_BYTES, 1: number of response bytes per read; range 1..8.
- BPS, 115_200: UART bit rate; used only for the default timeout.
- SYS_CLK_FREQ, 50_000_000: clk frequency in Hz.
- TIMEOUT_CYCLES, 20*SYS_CLK_FREQ/BPS: idle clk cycles allowed before and between response bytes; minimum 2.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cmd  in  CMD_BYTES*DATA_WIDTH  command packet.
- uart_valid  in  1  cmd valid.
- uart_ready  out  1  engine idle; accepts cmd.
- read_data  out  RD_BYTES*DATA_WIDTH  assembled response, MSByte first.
- read_valid  out  1  one-cycle pulse; read_data valid.
- rd_timeout  out  1  one-cycle pulse; read aborted.
- cmd_done  out  1  one-cycle pulse at the end of any command (write, read or timeout).
- tx_data  out  DATA_WIDTH  byte to send.
- tx_en  out  1  one-cycle pulse; tx_data is sampled.
- tx_done  in  1  one-cycle pulse; current byte has been sent.
- rx_data  in  DATA_WIDTH  received byte.
- rx_done  in  1  one-cycle pulse; rx_data valid.

Behaviour:
- Reset: a synchronous rst forces all outputs to 0 (tx_data, read_data, all pulses and uart_ready) and state to IDLE. The same applies mid-command: the packet is abandoned, and no cmd_done or read_valid is produced.
- uart_ready = (state==IDLE) & ~rst.
- Handshake: a transfer occurs when uart_valid & uart_ready. cmd is captured into a shift register on that edge. cmd may change afterwards.
- FSM states: IDLE, TX_SEND, TX_WAIT, RX_WAIT, DONE.
- IDLE -> TX_SEND on handshake.
- TX_SEND: tx_en=1 for exactly one cycle with tx_data = top byte of the shift register. Then go to TX_WAIT.
- TX_WAIT:
  - On tx_done, shift left by DATA_WIDTH and increment the byte count.
  - If bytes remain, go to TX_SEND; the next tx_en occurs on the cycle after tx_done.
  - Otherwise go to RX_WAIT if the command is a read, or DONE if it is a write.
  - tx_done seen outside TX_WAIT is ignored.
- Latency: the first tx_en fires 1 cycle after the handshake. Each subsequent tx_en fires 1 cycle after the preceding tx_done.
- RX_WAIT:
  - Entry clears the timeout counter and the rx byte count.
  - On rx_done: shift rx_data into the LSByte of the response register, increment the count, and clear the timeout counter.
  - When the count reaches RD_BYTES: read_data <= response register and go to DONE with read_valid pulsing in DONE.
  - If no rx_done occurs and the counter reaches TIMEOUT_CYCLES-1: pulse rd_timeout, leave read_data unchanged, and go to DONE.
  - If rx_done and timeout expiry fall in the same cycle, rx_done wins.
- rx_done outside RX_WAIT, e.g. during TX, is ignored and discarded.
- DONE: cmd_done=1 (plus read_valid on a successful read). Next state is IDLE, so uart_ready rises 1 cycle after cmd_done.
- read_data holds its value until the next successful read or rst.
- Widths:
  - The byte counter is clog2(max(CMD_BYTES,RD_BYTES)+1) bits.
  - The timeout counter is clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.
  - CMD_BYTES=1 is legal: the packet is a single byte with R/W in bit 7.

Decomposition:
- Package uart_pkg:
  - FSM state encoding.
  - Width helper constants/functions: CMD_W, RSP_W, CNT_W, TO_W.
  - Default timeout expression.
- Sub-module uart_timeout_cnt: clear/enable inputs, expire pulse output, parametrised by TIMEOUT_CYCLES.

Test Plan:
- Write: CMD_BYTES=2, cmd=16'h8A5C, with tx_done returned 10 cycles after each tx_en -> tx_en pulses with tx_data 8'h8A then 8'h5C. Expect cmd_done 1 cycle after the second tx_done, uart_ready the cycle after that, and no read_valid.
- Read: cmd=16'h0312, RD_BYTES=2, rx bytes 8'hDE then 8'hAD -> read_valid pulse with read_data=16'hDEAD and cmd_done in the same cycle.
- Timeout: TIMEOUT_CYCLES=16, read command, only one rx byte sent -> rd_timeout pulses 16 cycles after that byte. read_data keeps its previous value; no read_valid.
- Race: rx_done asserted in the exact expiry cycle -> byte accepted, no rd_timeout. Stray rx_done during TX_WAIT is ignored.
- Back-pressure: uart_valid held high for consecutive commands -> the second command is accepted only on the cycle after cmd_done; uart_ready is never high during TX or RX.
- Reset mid-read: rst pulsed after the first rx byte -> all outputs 0 in the next cycle and no read_valid or cmd_done. A following write completes normally.
